// File: rtl/corr_pkg.sv
// Shared definitions for the correlator read sequencer: default widths,
// sequencer state encoding and the MAC strobe bundle.
package corr_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_COUNT_W = 5;
  localparam int DEF_LAG_W   = 4;
  localparam int DEF_RAM_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic en;
    logic clr;
    logic last;
  } strobe_t;

endpackage

// File: rtl/corr_delay.sv
// LAT-deep shift register carrying the MAC strobes and lag tag so they line
// up with RAM read data. The lag tag only moves with a valid strobe, so the
// output tag holds its last value between accumulations.
module corr_delay
  import corr_pkg::*;
#(
  parameter int LAT   = DEF_RAM_LAT,
  parameter int LAG_W = DEF_LAG_W
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             flush,
  input  strobe_t          stb_i,
  input  logic [LAG_W-1:0] lag_i,
  output strobe_t          stb_o,
  output logic [LAG_W-1:0] lag_o
);

  strobe_t          stb_q [LAT];
  logic [LAG_W-1:0] lag_q [LAT];

  always_ff @(posedge ck) begin
    if (rst) begin
      // NOTE: these stages are a handful of flops rather than a RAM array, so
      // clearing every entry on reset is cheap and keeps outputs defined.
      for (int i = 0; i < LAT; i++) begin
        stb_q[i] <= '0;
        lag_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < LAT; i++) begin
        stb_q[i] <= '0;
      end
    end else begin
      stb_q[0] <= stb_i;
      if (stb_i.en) lag_q[0] <= lag_i;
      for (int i = 1; i < LAT; i++) begin
        stb_q[i] <= stb_q[i-1];
        if (stb_q[i-1].en) lag_q[i] <= lag_q[i-1];
      end
    end
  end

  assign stb_o = stb_q[LAT-1];
  assign lag_o = lag_q[LAT-1];

endmodule

// File: rtl/corr_seq.sv
// Multi-lag read sequencer: sweeps lags x count reads over the x/y sample RAMs
// and emits latency-aligned MAC enable/clear/last strobes with a lag tag.
module corr_seq
  import corr_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int COUNT_W = DEF_COUNT_W,
  parameter int LAG_W   = DEF_LAG_W,
  parameter int RAM_LAT = DEF_RAM_LAT
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [COUNT_W-1:0] count,
  input  logic [LAG_W-1:0]   lags,
  input  logic [ADDR_W-1:0]  x_base,
  input  logic [ADDR_W-1:0]  y_base,
  output logic [ADDR_W-1:0]  x_raddr,
  output logic [ADDR_W-1:0]  y_raddr,
  output logic               ren,
  output logic               mac_en,
  output logic               mac_clr,
  output logic               mac_last,
  output logic [LAG_W-1:0]   lag_out,
  output logic               busy,
  output logic               done
);

  localparam int DRAIN_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  state_e             state_q;
  logic [COUNT_W-1:0] count_q, idx_q, idx_d;
  logic [LAG_W-1:0]   lags_q, lag_q, lag_d;
  logic [ADDR_W-1:0]  x_base_q, y_base_q;
  logic [ADDR_W-1:0]  x_raddr_q, y_raddr_q, x_raddr_d, y_raddr_d;
  logic [DRAIN_W-1:0] drain_q;
  logic               ren_q, busy_q, done_q;
  logic               idx_last, lag_last;
  strobe_t            stb, mac_stb;

  // Next read position and its addresses; all sums wrap at ADDR_W bits.
  always_comb begin
    idx_last  = (idx_q == count_q - COUNT_W'(1));
    lag_last  = (lag_q == lags_q - LAG_W'(1));
    idx_d     = idx_last ? '0 : idx_q + COUNT_W'(1);
    lag_d     = idx_last ? lag_q + LAG_W'(1) : lag_q;
    x_raddr_d = x_base_q + ADDR_W'(lag_d) + ADDR_W'(idx_d);
    y_raddr_d = y_base_q + ADDR_W'(idx_d);
    stb.en    = ren_q;
    stb.clr   = ren_q && (idx_q == '0);
    stb.last  = ren_q && idx_last;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      lags_q    <= '0;
      x_base_q  <= '0;
      y_base_q  <= '0;
      idx_q     <= '0;
      lag_q     <= '0;
      x_raddr_q <= '0;
      y_raddr_q <= '0;
      drain_q   <= '0;
      ren_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; the default below makes done a single-cycle pulse.
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            if (count != '0 && lags != '0) begin
              state_q   <= ST_RUN;
              count_q   <= count;
              lags_q    <= lags;
              x_base_q  <= x_base;
              y_base_q  <= y_base;
              idx_q     <= '0;
              lag_q     <= '0;
              x_raddr_q <= x_base;
              y_raddr_q <= y_base;
              ren_q     <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort || (idx_last && lag_last)) begin
            state_q   <= abort ? ST_IDLE : ST_DRAIN;
            busy_q    <= !abort;
            ren_q     <= 1'b0;
            x_raddr_q <= '0;
            y_raddr_q <= '0;
            drain_q   <= DRAIN_W'(RAM_LAT - 1);
          end else begin
            idx_q     <= idx_d;
            lag_q     <= lag_d;
            x_raddr_q <= x_raddr_d;
            y_raddr_q <= y_raddr_d;
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (drain_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - DRAIN_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  corr_delay #(
    .LAT  (RAM_LAT),
    .LAG_W(LAG_W)
  ) u_delay (
    .ck   (ck),
    .rst  (rst),
    .flush(rst | abort),
    .stb_i(stb),
    .lag_i(lag_q),
    .stb_o(mac_stb),
    .lag_o(lag_out)
  );

  assign x_raddr  = x_raddr_q;
  assign y_raddr  = y_raddr_q;
  assign ren      = ren_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mac_en   = mac_stb.en;
  assign mac_clr  = mac_stb.clr;
  assign mac_last = mac_stb.last;

endmodule

// File: tb/tb_corr_seq.sv
// Self-checking bench for corr_seq: two instances (RAM latency 1 and 2) share
// stimulus and are compared every cycle against a sweep-level reference model.
module tb_corr_seq;
  import corr_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int CW = DEF_COUNT_W;
  localparam int LW = DEF_LAG_W;

  typedef struct packed {
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    logic          ren;
    logic          me;
    logic          clr;
    logic          last;
    logic [LW-1:0] lag;
    logic          busy;
    logic          done;
  } obs_t;

  typedef struct {
    bit act;
    int t0, cnt, lg, xb, yb, zdone, lag_hold;
  } model_t;

  typedef struct {
    int cnt, lg, xb, yb;
    int dd1, dd2, ren_n, pair_n;
  } vec_t;

  logic          ck = 1'b0;
  logic          rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [CW-1:0] count = '0;
  logic [LW-1:0] lags = '0;
  logic [AW-1:0] x_base = '0, y_base = '0;

  logic [1:0][AW-1:0] x_r, y_r;
  logic [1:0][LW-1:0] lag_o;
  logic [1:0]         ren, mac_en, mac_clr, mac_last, busy, done;
  obs_t               obs [2];

  int n_tests = 0, n_fail = 0, cyc = 0;
  model_t mdl [2];
  int done_n [2], done_cyc [2], ren_n [2], clr_n [2], last_n [2];

  always #5 ck = ~ck;

  corr_seq #(.RAM_LAT(1)) dut1 (
    .ck(ck), .rst(rst), .start(start), .abort(abort), .count(count), .lags(lags),
    .x_base(x_base), .y_base(y_base), .x_raddr(x_r[0]), .y_raddr(y_r[0]),
    .ren(ren[0]), .mac_en(mac_en[0]), .mac_clr(mac_clr[0]), .mac_last(mac_last[0]),
    .lag_out(lag_o[0]), .busy(busy[0]), .done(done[0]));

  corr_seq #(.RAM_LAT(2)) dut2 (
    .ck(ck), .rst(rst), .start(start), .abort(abort), .count(count), .lags(lags),
    .x_base(x_base), .y_base(y_base), .x_raddr(x_r[1]), .y_raddr(y_r[1]),
    .ren(ren[1]), .mac_en(mac_en[1]), .mac_clr(mac_clr[1]), .mac_last(mac_last[1]),
    .lag_out(lag_o[1]), .busy(busy[1]), .done(done[1]));

  assign obs[0] = {x_r[0], y_r[0], ren[0], mac_en[0], mac_clr[0], mac_last[0], lag_o[0], busy[0], done[0]};
  assign obs[1] = {x_r[1], y_r[1], ren[1], mac_en[1], mac_clr[1], mac_last[1], lag_o[1], busy[1], done[1]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected outputs in cycle c: sample k of the sweep is read in cycle t0+1+k
  // and accumulated RAM latency cycles later; done follows the last accumulation.
  function automatic obs_t model_obs(int i, int c);
    obs_t   o;
    model_t m   = mdl[i];
    int     lat = i + 1;
    int     n   = m.cnt * m.lg;
    int     k   = c - m.t0 - 1;
    int     q   = k - lat;
    o = '0;
    if (m.act && k >= 0 && k < n) begin
      o.ren = 1'b1;
      o.x   = AW'((m.xb + k / m.cnt + k % m.cnt) % 256);
      o.y   = AW'((m.yb + k % m.cnt) % 256);
    end
    if (m.act && q >= 0 && q < n) begin
      o.me   = 1'b1;
      o.clr  = (q % m.cnt == 0);
      o.last = (q % m.cnt == m.cnt - 1);
      o.lag  = LW'(q / m.cnt);
    end else begin
      o.lag = LW'(m.lag_hold);
    end
    o.busy = m.act && k >= 0 && k < n + lat;
    o.done = (m.act && k == n + lat) || (m.zdone == c);
    return o;
  endfunction

  task automatic model_step(input int i);
    obs_t now = model_obs(i, cyc);
    if (rst) begin
      mdl[i] = '{default: 0};
      mdl[i].zdone = -1;
    end else if (now.busy) begin
      if (abort) mdl[i].act = 1'b0;
    end else if (start && !abort) begin
      if (count != 0 && lags != 0) begin
        mdl[i].act   = 1'b1;
        mdl[i].t0    = cyc;
        mdl[i].cnt   = int'(count);
        mdl[i].lg    = int'(lags);
        mdl[i].xb    = int'(x_base);
        mdl[i].yb    = int'(y_base);
        mdl[i].zdone = -1;
      end else begin
        mdl[i].act   = 1'b0;
        mdl[i].zdone = cyc + 1;
      end
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      done_n[i] = 0; done_cyc[i] = -1; ren_n[i] = 0; clr_n[i] = 0; last_n[i] = 0;
    end
  endtask

  task automatic tick();
    obs_t e;
    for (int i = 0; i < 2; i++) model_step(i);
    @(posedge ck);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      e = model_obs(i, cyc);
      check($sformatf("L%0d cycle %0d outputs", i + 1, cyc), 32'(obs[i]), 32'(e));
      if (e.me) mdl[i].lag_hold = int'(e.lag);
      if (done[i]) begin done_n[i]++; done_cyc[i] = cyc; end
      ren_n[i]  += int'(ren[i]);
      clr_n[i]  += int'(mac_clr[i]);
      last_n[i] += int'(mac_last[i]);
    end
  endtask

  task automatic run_to_done(input int budget);
    for (int w = 0; w < budget && !(done_n[0] > 0 && done_n[1] > 0); w++) tick();
  endtask

  vec_t tbl [7];
  int   s;

  initial begin
    tbl[0] = '{12, 1, 8'h00, 8'h00, 14, 15, 12, 1};
    tbl[1] = '{4, 3, 8'hFE, 8'h10, 14, 15, 12, 3};
    tbl[2] = '{0, 5, 8'h33, 8'h44, 1, 1, 0, 0};
    tbl[3] = '{3, 0, 8'h01, 8'h02, 1, 1, 0, 0};
    tbl[4] = '{1, 2, 8'h80, 8'h7F, 4, 5, 2, 2};
    tbl[5] = '{31, 15, 8'hF0, 8'hE0, 467, 468, 465, 15};
    tbl[6] = '{1, 1, 8'hFF, 8'hFF, 3, 4, 1, 1};
    for (int i = 0; i < 2; i++) begin
      mdl[i] = '{default: 0};
      mdl[i].zdone = -1;
    end
    clear_stats();

    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) check($sformatf("reset state L%0d", i + 1), 32'(obs[i]), 32'd0);

    // Directed sweeps: done latency, read count and clr/last pair counts.
    for (int v = 0; v < 7; v++) begin
      count  = CW'(tbl[v].cnt);
      lags   = LW'(tbl[v].lg);
      x_base = AW'(tbl[v].xb);
      y_base = AW'(tbl[v].yb);
      start  = 1'b1;
      clear_stats();
      s = cyc;
      tick();
      start = 1'b0;
      run_to_done(1000);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("vec%0d L%0d done delay", v, i + 1), done_cyc[i] - s, (i == 0) ? tbl[v].dd1 : tbl[v].dd2);
        check($sformatf("vec%0d L%0d ren cycles", v, i + 1), ren_n[i], tbl[v].ren_n);
        check($sformatf("vec%0d L%0d clr count", v, i + 1), clr_n[i], tbl[v].pair_n);
        check($sformatf("vec%0d L%0d last count", v, i + 1), last_n[i], tbl[v].pair_n);
      end
      tick();
    end

    // Abort in the third RUN cycle, then an immediate clean restart.
    count = CW'(8); lags = LW'(2); x_base = 8'h20; y_base = 8'h40;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    clear_stats();
    tick();
    abort = 1'b0;
    for (int i = 0; i < 2; i++)
      check($sformatf("abort strobes L%0d", i + 1), {mac_last[i], mac_clr[i], mac_en[i], ren[i], busy[i]}, 32'd0);
    x_base = 8'h50;
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("restart x addr L%0d", i + 1), x_r[i], 32'h50);
      check($sformatf("restart ren L%0d", i + 1), ren[i], 32'd1);
    end
    run_to_done(200);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("abort no extra done L%0d", i + 1), done_n[i], 32'd1);
      check($sformatf("restart done delay L%0d", i + 1), done_cyc[i] - s, 1 + 16 + i + 1);
    end
    tick();

    // start pulsed while busy must be ignored.
    count = CW'(1); lags = LW'(2); x_base = 8'h05; y_base = 8'h09;
    start = 1'b1;
    clear_stats();
    s = cyc;
    tick();
    count = CW'(3); lags = LW'(3);
    tick();
    start = 1'b0;
    run_to_done(200);
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("busy start done delay L%0d", i + 1), done_cyc[i] - s, 4 + i);
      check($sformatf("busy start single done L%0d", i + 1), done_n[i], 32'd1);
      check($sformatf("busy start reads L%0d", i + 1), ren_n[i], 32'd2);
      check($sformatf("busy start clr L%0d", i + 1), clr_n[i], 32'd2);
    end

    // Reset in the middle of a sweep.
    count = CW'(10); lags = LW'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) check($sformatf("mid-run reset L%0d", i + 1), 32'(obs[i]), 32'd0);
    tick();

    // Random traffic: back-to-back starts, aborts and occasional resets.
    for (int n = 0; n < 2500; n++) begin
      count  = CW'($urandom_range(0, 6));
      lags   = LW'($urandom_range(0, 3));
      x_base = AW'($urandom);
      y_base = AW'($urandom);
      start  = ($urandom % 4 == 0);
      abort  = ($urandom % 40 == 0);
      rst    = ($urandom % 500 == 0);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    for (int n = 0; n < 60; n++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/corr_seq.md
# corr_seq

Multi-lag read sequencer for the correlator datapath. It replaces the single-pass fetch counter with a parametrised engine that sweeps `lags` lag offsets of `count` samples each. It drives read addresses into the x and y sample RAMs (`dpram`). It also drives RAM-latency-aligned enable, clear and last strobes into `mac`, plus a lag tag so downstream `highest_bit`/`shifter` stages know which lag each accumulator result belongs to.

## Interface
Parameters:
- `ADDR_W`, 8: RAM address width; all addresses wrap modulo 2^ADDR_W.
- `COUNT_W`, 5: width of the per-lag sample count.
- `LAG_W`, 4: width of the lag count and lag index.
- `RAM_LAT`, 1: RAM read latency in cycles (≥1); sets the delay on the MAC strobes.

Ports:
- `ck` in 1: clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep; sampled only when idle.
- `abort` in 1: synchronous cancel of a running sweep.
- `count` in COUNT_W: samples per lag; latched at start.
- `lags` in LAG_W: number of lags; latched at start.
- `x_base` in ADDR_W: x start address for lag 0; latched at start.
- `y_base` in ADDR_W: y start address; latched at start.
- `x_raddr` out ADDR_W: x RAM read address.
- `y_raddr` out ADDR_W: y RAM read address.
- `ren` out 1: read enable to both RAMs.
- `mac_en` out 1: `ren` delayed by RAM_LAT.
- `mac_clr` out 1: high with the first `mac_en` of each lag.
- `mac_last` out 1: high with the final `mac_en` of each lag.
- `lag_out` out LAG_W: lag index aligned with `mac_en`.
- `busy` out 1: sweep in progress, including drain.
- `done` out 1: one-cycle pulse at sweep completion.

## Operation
- States are IDLE, RUN and DRAIN.
- IDLE → RUN on `start` when `count`≠0 and `lags`≠0. Inputs are latched and lag=0, idx=0.
- If `start` arrives in IDLE with `count`=0 or `lags`=0, no reads are issued. `done` pulses on the next cycle and `busy` stays 0.
- In RUN, each cycle issues one read: `x_raddr` = x_base + lag + idx and `y_raddr` = y_base + idx, both with the ADDR_W-bit sum truncated (wrap).
  - idx advances to count-1, then resets to 0 while lag increments.
  - Lags run back to back with no gap cycle.
- After the read with lag=lags-1 and idx=count-1, RUN → DRAIN.
- DRAIN waits RAM_LAT cycles, until the final `mac_en` has been issued, then → IDLE and pulses `done`.
- `start` is ignored while `busy`=1.
- `abort` in RUN or DRAIN forces IDLE on the next edge:
  - `ren`, `mac_en`, `mac_clr` and `mac_last` are 0 from that edge.
  - The strobe pipeline is flushed.
  - No `done` pulse is issued.
- `abort` in IDLE has no effect. If `abort` and `start` are high together in IDLE, `abort` wins and nothing starts.
- `rst` has the same effect as `abort` and additionally zeroes all registers.
- When idle, `x_raddr` and `y_raddr` are held at 0.

## Timing
- Reset values: all outputs are 0.
- Start takes effect at edge T. From edge T+1:
  - `ren`=1, `x_raddr`=x_base, `y_raddr`=y_base, `busy`=1.
  - `ren` stays high for exactly count·lags consecutive cycles.
- `mac_en`, `mac_clr`, `mac_last` and `lag_out` equal the values `ren`, first-of-lag, last-of-lag and lag had RAM_LAT cycles earlier, so they line up with `rdata`.
- When `count`=1, `mac_clr` and `mac_last` are high in the same cycle.
- `done` is high in the cycle after the final `mac_en`, which is cycle T+1+count·lags+RAM_LAT. `busy` falls in that same cycle.
- A new `start` is accepted in the `done` cycle. Its first `ren` appears on the following cycle.
- `lag_out` holds its last value while `mac_en`=0.

## Structure
- The shared package `corr_pkg` holds the state encoding (IDLE/RUN/DRAIN) and the default widths, which are shared with `mac` and the test bench.
- The sub-module `corr_delay` is a RAM_LAT-deep shift register carrying {en, clr, last, lag}. It has a synchronous flush input driven by `rst`|`abort`.

## Test plan
- count=12, lags=1, x_base=0, y_base=0, RAM_LAT=1: `ren` is high for 12 cycles with addresses 0..11. Exactly one `mac_clr` is seen, on the first `mac_en`, and one `mac_last`, on the 12th. `done` arrives at T+14.
- count=4, lags=3, x_base=0xFE, y_base=0x10: the x address sequence is FE,FF,00,01 / FF,00,01,02 / 00,01,02,03, with y repeating 10..13. `lag_out` reads 0,1,2. There are three clr/last pairs and 12 `mac_en` cycles in total.
- count=0 or lags=0: `ren` never rises, `busy` stays 0, and `done` pulses at T+1.
- `abort` in the 3rd RUN cycle of count=8, lags=2: all strobes are 0 from the next edge and no `done` is issued. A `start` on the following cycle gives a clean sweep from x_base.
- RAM_LAT=2, count=1, lags=2: `mac_clr` and `mac_last` are coincident on both `mac_en` cycles, each 2 cycles after its `ren`. `done` arrives at T+5. A `start` pulsed while `busy`=1 is ignored.
- `rst` asserted mid-RUN: all outputs are 0 on the next edge.
